// File: rtl/npu_pkg.sv
// Shared types and default geometry for the NPU tile scheduler slice.
package npu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StFeed,
    StWaitDone,
    StDrain,
    StDone
  } sched_state_e;

  localparam int unsigned ARRAY_SIZE_DEF = 4;
  localparam int unsigned K_WIDTH        = $clog2(ARRAY_SIZE_DEF);
  localparam int unsigned TILE_ELEMS     = ARRAY_SIZE_DEF * ARRAY_SIZE_DEF;

endpackage

// File: rtl/npu_tile_coord.sv
// Maps a tile position plus a core result index to global output row/col.
module npu_tile_coord #(
  parameter int unsigned ARRAY_SIZE  = 4,
  parameter int unsigned TILE_W      = 8,
  parameter int unsigned INDEX_WIDTH = $clog2(ARRAY_SIZE * ARRAY_SIZE),
  parameter int unsigned RC_WIDTH    = TILE_W + $clog2(ARRAY_SIZE)
) (
  input  logic [TILE_W-1:0]      tile_m_i,
  input  logic [TILE_W-1:0]      tile_n_i,
  input  logic [INDEX_WIDTH-1:0] index_i,
  output logic [RC_WIDTH-1:0]    row_o,
  output logic [RC_WIDTH-1:0]    col_o
);

  logic [INDEX_WIDTH-1:0] sub_row;
  logic [INDEX_WIDTH-1:0] sub_col;

  // Core streams results row-major within the tile.
  assign sub_row = index_i / INDEX_WIDTH'(ARRAY_SIZE);
  assign sub_col = index_i % INDEX_WIDTH'(ARRAY_SIZE);

  assign row_o = RC_WIDTH'(tile_m_i) * RC_WIDTH'(ARRAY_SIZE) + RC_WIDTH'(sub_row);
  assign col_o = RC_WIDTH'(tile_n_i) * RC_WIDTH'(ARRAY_SIZE) + RC_WIDTH'(sub_col);

endmodule

// File: rtl/npu_tile_scheduler.sv
// Tile scheduler: walks an m x n grid of output tiles through one npu_core, feeding operand
// vectors and relaying the core's streamed results with global coordinates.
module npu_tile_scheduler
  import npu_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE  = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH   = 20,
  parameter int unsigned TILE_W      = 8,
  parameter int unsigned INDEX_WIDTH = $clog2(ARRAY_SIZE * ARRAY_SIZE),
  parameter int unsigned RC_WIDTH    = TILE_W + $clog2(ARRAY_SIZE)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             job_start,
  input  logic [TILE_W-1:0]                job_m_tiles,
  input  logic [TILE_W-1:0]                job_n_tiles,
  output logic                             sched_busy,
  output logic                             job_done,
  output logic                             rsp_err,
  output logic                             rd_req_valid,
  input  logic                             rd_req_ready,
  output logic [TILE_W-1:0]                rd_req_tile_m,
  output logic [TILE_W-1:0]                rd_req_tile_n,
  output logic [$clog2(ARRAY_SIZE)-1:0]    rd_req_k,
  input  logic                             rd_rsp_valid,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] rd_rsp_a,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] rd_rsp_b,
  output logic                             core_start,
  output logic                             core_in_valid,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] core_a_stream,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] core_b_stream,
  input  logic                             core_busy,
  input  logic                             core_done,
  input  logic                             core_result_valid,
  input  logic [ACC_WIDTH-1:0]             core_result_data,
  input  logic [INDEX_WIDTH-1:0]           core_result_index,
  output logic                             core_result_ready,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_WIDTH-1:0]             out_data,
  output logic [RC_WIDTH-1:0]              out_row,
  output logic [RC_WIDTH-1:0]              out_col,
  output logic                             out_last
);

  localparam int unsigned KW   = $clog2(ARRAY_SIZE);
  localparam int unsigned CntW = KW + 1;
  localparam logic [CntW-1:0]        CntMax  = CntW'(ARRAY_SIZE);
  localparam logic [CntW-1:0]        CntLast = CntW'(ARRAY_SIZE - 1);
  localparam logic [INDEX_WIDTH-1:0] LastIdx = INDEX_WIDTH'(ARRAY_SIZE * ARRAY_SIZE - 1);

  sched_state_e      state_q, state_d;
  logic [TILE_W-1:0] m_tiles_q, m_tiles_d;
  logic [TILE_W-1:0] n_tiles_q, n_tiles_d;
  logic [TILE_W-1:0] tile_m_q, tile_m_d;
  logic [TILE_W-1:0] tile_n_q, tile_n_d;
  logic [CntW-1:0]   req_cnt_q, req_cnt_d;
  logic [CntW-1:0]   rsp_cnt_q, rsp_cnt_d;
  logic              core_start_q, core_start_d;
  logic              zero_done_q, zero_done_d;
  logic              rsp_err_q, rsp_err_d;

  logic in_feed;
  logic in_drain;
  logic rsp_accept;
  logic req_fire;
  logic out_fire;
  logic idx_last;
  logic tile_last;
  logic [RC_WIDTH-1:0] coord_row;
  logic [RC_WIDTH-1:0] coord_col;

  assign in_feed    = (state_q == StFeed);
  assign in_drain   = (state_q == StDrain);
  assign rsp_accept = in_feed && rd_rsp_valid && (rsp_cnt_q < CntMax);
  assign req_fire   = rd_req_valid && rd_req_ready;
  assign out_fire   = in_drain && core_result_valid && out_ready;
  assign idx_last   = (core_result_index == LastIdx);
  assign tile_last  = (tile_m_q == m_tiles_q - TILE_W'(1)) &&
                      (tile_n_q == n_tiles_q - TILE_W'(1));

  npu_tile_coord #(
    .ARRAY_SIZE (ARRAY_SIZE),
    .TILE_W     (TILE_W),
    .INDEX_WIDTH(INDEX_WIDTH),
    .RC_WIDTH   (RC_WIDTH)
  ) u_coord (
    .tile_m_i(tile_m_q),
    .tile_n_i(tile_n_q),
    .index_i (core_result_index),
    .row_o   (coord_row),
    .col_o   (coord_col)
  );

  always_comb begin
    state_d      = state_q;
    m_tiles_d    = m_tiles_q;
    n_tiles_d    = n_tiles_q;
    tile_m_d     = tile_m_q;
    tile_n_d     = tile_n_q;
    req_cnt_d    = req_cnt_q;
    rsp_cnt_d    = rsp_cnt_q;
    core_start_d = 1'b0;
    zero_done_d  = 1'b0;
    rsp_err_d    = rsp_err_q;

    // An accepted job clears the error, but a stray response in the same cycle still sets it.
    if ((state_q == StIdle) && job_start) begin
      rsp_err_d = 1'b0;
    end
    if (rd_rsp_valid && !rsp_accept) begin
      rsp_err_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (job_start) begin
          if ((job_m_tiles != '0) && (job_n_tiles != '0)) begin
            m_tiles_d = job_m_tiles;
            n_tiles_d = job_n_tiles;
            tile_m_d  = '0;
            tile_n_d  = '0;
            state_d   = StStart;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end

      StStart: begin
        req_cnt_d = '0;
        rsp_cnt_d = '0;
        // core_start is registered, so the pulse lands on the final START cycle.
        if (core_start_q) begin
          state_d = StFeed;
        end else if (!core_busy) begin
          core_start_d = 1'b1;
        end
      end

      StFeed: begin
        if (req_fire) begin
          req_cnt_d = req_cnt_q + CntW'(1);
        end
        if (rsp_accept) begin
          rsp_cnt_d = rsp_cnt_q + CntW'(1);
          if (rsp_cnt_q == CntLast) begin
            state_d = StWaitDone;
          end
        end
      end

      StWaitDone: begin
        if (core_done) begin
          state_d = StDrain;
        end
      end

      StDrain: begin
        if (out_fire && idx_last) begin
          if (tile_last) begin
            state_d = StDone;
          end else begin
            state_d = StStart;
            if (tile_n_q == n_tiles_q - TILE_W'(1)) begin
              tile_n_d = '0;
              tile_m_d = tile_m_q + TILE_W'(1);
            end else begin
              tile_n_d = tile_n_q + TILE_W'(1);
            end
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      m_tiles_q    <= '0;
      n_tiles_q    <= '0;
      tile_m_q     <= '0;
      tile_n_q     <= '0;
      req_cnt_q    <= '0;
      rsp_cnt_q    <= '0;
      core_start_q <= 1'b0;
      zero_done_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_tiles_q    <= m_tiles_d;
      n_tiles_q    <= n_tiles_d;
      tile_m_q     <= tile_m_d;
      tile_n_q     <= tile_n_d;
      req_cnt_q    <= req_cnt_d;
      rsp_cnt_q    <= rsp_cnt_d;
      core_start_q <= core_start_d;
      zero_done_q  <= zero_done_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign sched_busy = (state_q != StIdle);
  assign job_done   = (state_q == StDone) || zero_done_q;
  assign rsp_err    = rsp_err_q;

  assign rd_req_valid  = in_feed && (req_cnt_q < CntMax);
  assign rd_req_tile_m = tile_m_q;
  assign rd_req_tile_n = tile_n_q;
  assign rd_req_k      = req_cnt_q[KW-1:0];

  assign core_start    = core_start_q;
  assign core_in_valid = rsp_accept;
  assign core_a_stream = in_feed ? rd_rsp_a : '0;
  assign core_b_stream = in_feed ? rd_rsp_b : '0;

  assign core_result_ready = in_drain && out_ready;
  assign out_valid         = in_drain && core_result_valid;
  assign out_data          = in_drain ? core_result_data : '0;
  assign out_row           = in_drain ? coord_row : '0;
  assign out_col           = in_drain ? coord_col : '0;
  assign out_last          = out_valid && idx_last && tile_last;

endmodule

// File: tb/tb_npu_tile_scheduler.sv
// Bench for npu_tile_scheduler with a behavioural operand source and npu_core model.
module tb_npu_tile_scheduler;
  import npu_pkg::*;

  localparam int unsigned AS  = 4;
  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 20;
  localparam int unsigned TW  = 8;
  localparam int unsigned IW  = 4;
  localparam int unsigned RCW = 10;
  localparam int unsigned KW  = K_WIDTH;

  typedef struct {
    int m;
    int n;
    int af;
    int bf;
    bit ramp;
    bit rdy_toggle;
    bit stall;
    int exp_elems;
    int exp_starts;
    int exp_last_row;
    int exp_last_col;
  } job_vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic job_start;
  logic [TW-1:0] job_m_tiles, job_n_tiles;
  logic sched_busy, job_done, rsp_err;
  logic rd_req_valid, rd_req_ready;
  logic [TW-1:0] rd_req_tile_m, rd_req_tile_n;
  logic [KW-1:0] rd_req_k;
  logic rd_rsp_valid;
  logic [AS*DW-1:0] rd_rsp_a, rd_rsp_b;
  logic core_start, core_in_valid;
  logic [AS*DW-1:0] core_a_stream, core_b_stream;
  logic core_busy, core_done, core_result_valid, core_result_ready;
  logic [AW-1:0] core_result_data;
  logic [IW-1:0] core_result_index;
  logic out_valid, out_ready, out_last;
  logic [AW-1:0] out_data;
  logic [RCW-1:0] out_row, out_col;

  always #5 clk = ~clk;

  npu_tile_scheduler dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .job_start        (job_start),
    .job_m_tiles      (job_m_tiles),
    .job_n_tiles      (job_n_tiles),
    .sched_busy       (sched_busy),
    .job_done         (job_done),
    .rsp_err          (rsp_err),
    .rd_req_valid     (rd_req_valid),
    .rd_req_ready     (rd_req_ready),
    .rd_req_tile_m    (rd_req_tile_m),
    .rd_req_tile_n    (rd_req_tile_n),
    .rd_req_k         (rd_req_k),
    .rd_rsp_valid     (rd_rsp_valid),
    .rd_rsp_a         (rd_rsp_a),
    .rd_rsp_b         (rd_rsp_b),
    .core_start       (core_start),
    .core_in_valid    (core_in_valid),
    .core_a_stream    (core_a_stream),
    .core_b_stream    (core_b_stream),
    .core_busy        (core_busy),
    .core_done        (core_done),
    .core_result_valid(core_result_valid),
    .core_result_data (core_result_data),
    .core_result_index(core_result_index),
    .core_result_ready(core_result_ready),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_row          (out_row),
    .out_col          (out_col),
    .out_last         (out_last)
  );

  // Operand source: answers each accepted request exactly one cycle later.
  int cfg_m, cfg_n, cfg_af, cfg_bf;
  bit cfg_ramp;
  logic src_pend, inj_rsp;
  logic [TW-1:0] src_tm, src_tn;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_pend <= 1'b0;
      src_tm   <= '0;
      src_tn   <= '0;
    end else begin
      src_pend <= rd_req_valid && rd_req_ready;
      if (rd_req_valid && rd_req_ready) begin
        src_tm <= rd_req_tile_m;
        src_tn <= rd_req_tile_n;
      end
    end
  end

  assign rd_rsp_valid = src_pend | inj_rsp;

  always_comb begin
    rd_rsp_a = '0;
    rd_rsp_b = '0;
    for (int i = 0; i < AS; i++) begin
      rd_rsp_a[i*DW +: DW] = DW'(cfg_ramp ? cfg_af + i + int'(src_tm) : cfg_af);
      rd_rsp_b[i*DW +: DW] = DW'(cfg_ramp ? cfg_bf + i + int'(src_tn) : cfg_bf);
    end
  end

  // Core model: accumulates AS outer products, then streams results row-major.
  logic [1:0] c_phase;
  logic [2:0] c_cnt;
  logic [IW-1:0] c_idx;
  logic c_done;
  logic [AW-1:0] c_acc [AS*AS];

  always_ff @(posedge clk) begin
    c_done <= 1'b0;
    if (!rst_n) begin
      c_phase <= 2'd0;
      c_cnt   <= '0;
      c_idx   <= '0;
    end else begin
      case (c_phase)
        2'd0: if (core_start) begin
          c_phase <= 2'd1;
          c_cnt   <= '0;
          for (int i = 0; i < AS*AS; i++) c_acc[i] <= '0;
        end
        2'd1: if (core_in_valid) begin
          for (int i = 0; i < AS; i++)
            for (int j = 0; j < AS; j++)
              c_acc[i*AS+j] <= c_acc[i*AS+j] + AW'(core_a_stream[i*DW +: DW]) *
                               AW'(core_b_stream[j*DW +: DW]);
          c_cnt <= c_cnt + 3'd1;
          if (c_cnt == 3'(AS-1)) begin
            c_phase <= 2'd2;
            c_cnt   <= '0;
          end
        end
        2'd2: begin
          c_cnt <= c_cnt + 3'd1;
          if (c_cnt == 3'd2) begin
            c_phase <= 2'd3;
            c_done  <= 1'b1;
            c_idx   <= '0;
          end
        end
        default: if (core_result_ready) begin
          c_idx <= c_idx + IW'(1);
          if (c_idx == IW'(AS*AS-1)) c_phase <= 2'd0;
        end
      endcase
    end
  end

  assign core_busy         = (c_phase != 2'd0);
  assign core_done         = c_done;
  assign core_result_valid = (c_phase == 2'd3);
  assign core_result_data  = c_acc[c_idx];
  assign core_result_index = c_idx;

  int checks, errors;
  int n_out, n_last, n_start, n_done, n_reqv, n_req_acc, last_row, last_col;
  int e_tm, e_tn, e_idx, q_tm, q_tn, q_k;
  bit mon_en, prev_stall, prev_hold;
  logic [TW-1:0] prev_tm, prev_tn;
  logic [KW-1:0] prev_k;
  logic [AW-1:0] prev_data;
  job_vec_t vecs[5];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: monitor at the falling edge, return just after the next rising edge.
  task automatic tick();
    int i, j, av, bv;
    @(negedge clk);
    if (mon_en) begin
      if (core_start) n_start++;
      if (job_done) n_done++;
      if (rd_req_valid) n_reqv++;
      if (rd_req_valid && prev_stall) begin
        check("req_hold_k", rd_req_k, prev_k);
        check("req_hold_tm", rd_req_tile_m, prev_tm);
        check("req_hold_tn", rd_req_tile_n, prev_tn);
      end
      if (out_valid && prev_hold) check("out_hold_data", out_data, prev_data);
      if (rd_req_valid && rd_req_ready) begin
        check("req_k", rd_req_k, q_k);
        check("req_tm", rd_req_tile_m, q_tm);
        check("req_tn", rd_req_tile_n, q_tn);
        n_req_acc++;
        q_k++;
        if (q_k == AS) begin
          q_k = 0;
          q_tn++;
          if (q_tn == cfg_n) begin q_tn = 0; q_tm++; end
        end
      end
      if (out_valid && out_ready) begin
        i  = e_idx / AS;
        j  = e_idx % AS;
        av = cfg_ramp ? cfg_af + i + e_tm : cfg_af;
        bv = cfg_ramp ? cfg_bf + j + e_tn : cfg_bf;
        check("out_row", out_row, e_tm * AS + i);
        check("out_col", out_col, e_tn * AS + j);
        check("out_data", out_data, AS * av * bv);
        check("out_last", out_last,
              (e_tm == cfg_m - 1 && e_tn == cfg_n - 1 && e_idx == AS*AS - 1) ? 1 : 0);
        if (out_last) begin
          n_last++;
          last_row = int'(out_row);
          last_col = int'(out_col);
        end
        n_out++;
        e_idx++;
        if (e_idx == AS*AS) begin
          e_idx = 0;
          e_tn++;
          if (e_tn == cfg_n) begin e_tn = 0; e_tm++; end
        end
      end
      prev_stall = rd_req_valid && !rd_req_ready;
      prev_k     = rd_req_k;
      prev_tm    = rd_req_tile_m;
      prev_tn    = rd_req_tile_n;
      prev_hold  = out_valid && !out_ready;
      prev_data  = out_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic prep_job(input job_vec_t v);
    cfg_m = v.m; cfg_n = v.n; cfg_af = v.af; cfg_bf = v.bf; cfg_ramp = v.ramp;
    n_out = 0; n_last = 0; n_start = 0; n_done = 0; n_reqv = 0; n_req_acc = 0;
    last_row = -1; last_col = -1;
    e_tm = 0; e_tn = 0; e_idx = 0; q_tm = 0; q_tn = 0; q_k = 0;
    prev_stall = 1'b0; prev_hold = 1'b0; mon_en = 1'b1;
    job_m_tiles = TW'(v.m); job_n_tiles = TW'(v.n);
    out_ready = 1'b1; rd_req_ready = 1'b1;
  endtask

  task automatic run_job(input job_vec_t v, input string tag);
    int cyc, first_start;
    prep_job(v);
    job_start = 1'b1;
    cyc = 0;
    first_start = -1;
    while (n_done == 0 && cyc < 4000) begin
      tick();
      cyc++;
      job_start = 1'b0;
      if (core_start && first_start < 0) first_start = cyc;
      out_ready    = v.rdy_toggle ? cyc[0] : 1'b1;
      rd_req_ready = !(v.stall && cyc >= 4 && cyc < 9);
    end
    check({tag, "_timeout"}, (cyc < 4000) ? 1 : 0, 1);
    out_ready = 1'b1; rd_req_ready = 1'b1;
    repeat (3) tick();
    check({tag, "_done_cnt"}, n_done, 1);
    check({tag, "_elems"}, n_out, v.exp_elems);
    check({tag, "_starts"}, n_start, v.exp_starts);
    check({tag, "_reqs"}, n_req_acc, v.exp_starts * AS);
    check({tag, "_last_cnt"}, n_last, 1);
    check({tag, "_last_row"}, last_row, v.exp_last_row);
    check({tag, "_last_col"}, last_col, v.exp_last_col);
    check({tag, "_start_lat"}, first_start, 2);
    check({tag, "_idle"}, sched_busy, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    mon_en = 1'b0;
  endtask

  initial begin
    int cyc;
    job_vec_t rv;
    checks = 0; errors = 0; mon_en = 1'b0;
    rst_n = 1'b0; job_start = 1'b0; job_m_tiles = '0; job_n_tiles = '0;
    inj_rsp = 1'b0; out_ready = 1'b1; rd_req_ready = 1'b1;
    cfg_m = 1; cfg_n = 1; cfg_af = 0; cfg_bf = 0; cfg_ramp = 1'b0;

    //          m  n  af   bf  ramp tog stall elems starts lrow lcol
    vecs[0] = '{1, 1, 1,   1,   0,   0,  0,   16,   1,     3,   3};
    vecs[1] = '{2, 3, 2,   3,   1,   0,  0,   96,   6,     7,  11};
    vecs[2] = '{1, 2, 5,   7,   1,   1,  0,   32,   2,     3,   7};
    vecs[3] = '{1, 1, 3,   1,   1,   0,  1,   16,   1,     3,   3};
    vecs[4] = '{2, 1, 255, 255, 0,   0,  0,   32,   2,     7,   3};

    repeat (3) tick();
    check("rst_busy", sched_busy, 0);
    check("rst_done", job_done, 0);
    check("rst_err", rsp_err, 0);
    check("rst_req_valid", rd_req_valid, 0);
    check("rst_core_start", core_start, 0);
    check("rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    tick();

    // Stray response while idle: dropped and flagged.
    inj_rsp = 1'b1;
    #1;
    check("stray_not_fwd", core_in_valid, 0);
    tick();
    inj_rsp = 1'b0;
    check("stray_err", rsp_err, 1);

    // Empty jobs: done next cycle, no activity; the accepted start clears rsp_err.
    for (int z = 0; z < 2; z++) begin
      prep_job(vecs[0]);
      job_m_tiles = (z == 0) ? TW'(0) : TW'(1);
      job_n_tiles = (z == 0) ? TW'(3) : TW'(0);
      job_start = 1'b1;
      tick();
      job_start = 1'b0;
      check("zero_done", job_done, 1);
      check("zero_busy", sched_busy, 0);
      check("zero_err_clr", rsp_err, 0);
      tick();
      check("zero_done_pulse", job_done, 0);
      repeat (4) tick();
      check("zero_no_start", n_start, 0);
      check("zero_no_req", n_reqv, 0);
      mon_en = 1'b0;
    end

    for (int t = 0; t < 5; t++) run_job(vecs[t], $sformatf("job%0d", t));

    // Reset during the second tile's drain, then a fresh job.
    rv = '{1, 2, 2, 1, 1, 0, 0, 16, 1, 3, 3};
    prep_job(rv);
    job_start = 1'b1;
    cyc = 0;
    while (n_out < 20 && cyc < 2000) begin
      tick();
      cyc++;
      job_start = 1'b0;
    end
    check("rstmid_reach", (cyc < 2000) ? 1 : 0, 1);
    rst_n = 1'b0;
    tick();
    check("rstmid_busy", sched_busy, 0);
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_out_data", out_data, 0);
    check("rstmid_out_row", out_row, 0);
    check("rstmid_req_valid", rd_req_valid, 0);
    check("rstmid_core_ready", core_result_ready, 0);
    check("rstmid_done", job_done, 0);
    n_done = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("rstmid_no_stale_done", n_done, 0);
    check("rstmid_idle", sched_busy, 0);
    mon_en = 1'b0;
    run_job(vecs[0], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
